// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus responder.
//   - req_size codes (SZ_WORD, SZ_BYTE, SZ_HALF; code 3 is also a word)
//   - responder FSM state enum (IDLE, WAIT, RESP)
//   - is_word_size(): true for both word encodings
package mem_bus_pkg;

  localparam logic [1:0] SZ_WORD  = 2'd0;
  localparam logic [1:0] SZ_BYTE  = 2'd1;
  localparam logic [1:0] SZ_HALF  = 2'd2;
  localparam logic [1:0] SZ_WORD3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_word_size(input logic [1:0] size);
    return (size == SZ_WORD) || (size == SZ_WORD3);
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/response bundle between a processor (master) and the memory
// responder (slave).
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. While req_ready is 0 the request fields are ignored
// and may change freely. Each accepted request produces exactly one response,
// signalled by a single-cycle rsp_valid pulse; rsp_rdata/rsp_err are valid
// with that pulse and hold until the next response.
//
// Signals: req_valid, req_ready, req_we, req_addr[31:0],
//          req_wdata[CELL_WIDTH-1:0], req_size[1:0],
//          rsp_valid, rsp_rdata[CELL_WIDTH-1:0], rsp_err
interface mem_bus_responder_if #(
  parameter int CELL_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [CELL_WIDTH-1:0] req_wdata;
  logic [1:0]            req_size;
  logic                  rsp_valid;
  logic [CELL_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bus_array.sv
// Word-organised storage with per-byte write enables.
// Write is synchronous on the rising edge of clk; read is combinational from
// the same index. Contents are deliberately not reset.
//   clk   : clock
//   we    : write strobe
//   be    : byte enables (bit b covers wdata[8*b +: 8])
//   idx   : word index for both read and write
//   wdata : write data (already lane-replicated by the caller)
//   rdata : word at idx
module mem_bus_array #(
  parameter int CELL_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int AW         = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [CELL_WIDTH/8-1:0] be,
  input  logic [AW-1:0]           idx,
  input  logic [CELL_WIDTH-1:0]   wdata,
  output logic [CELL_WIDTH-1:0]   rdata
);
  localparam int NB = CELL_WIDTH / 8;

  logic [CELL_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/mem_bus_responder.sv
// Memory bus responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, performs the access against mem_bus_array and returns a one-cycle
// response pulse.
//
// Ports:
//   CLK       : clock, rising edge
//   RST       : asynchronous active-low reset
//   bus       : mem_bus_responder_if.slave (request/response bundle)
//   dbg_state : current FSM state
//
// Build option MEM_BUS_RESPONDER_ERR_EN: when defined, out-of-range word
// indices and misaligned half/word accesses are rejected (rsp_err=1, no write,
// rsp_rdata=0). When undefined, the index wraps modulo MEM_DEPTH, misaligned
// addresses are aligned down and rsp_err is always 0.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int CELL_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  mem_bus_responder_if.slave bus,
  output state_e             dbg_state
);
  localparam int NB = CELL_WIDTH / 8;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [CELL_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic [CELL_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  // Holds req_ready low until the first edge after reset release.
  logic                  ready_en_q;

  logic [31:0]           idx32;
  logic                  acc_err;
  logic [1:0]            lane;
  logic [AW-1:0]         mem_idx;
  logic [NB-1:0]         mem_be;
  logic [CELL_WIDTH-1:0] mem_wdata;
  logic [CELL_WIDTH-1:0] mem_rdata;
  logic [CELL_WIDTH-1:0] load_mask;
  logic [CELL_WIDTH-1:0] load_data;
  logic                  access;
  logic                  mem_we;
  logic                  unused_idx_bits;

  // ---------------- address decode of the latched request ----------------
`ifdef MEM_BUS_RESPONDER_ERR_EN
  assign idx32   = {2'b00, addr_q[31:2]};
  assign acc_err = (idx32 >= 32'(MEM_DEPTH))
                 || ((size_q == SZ_HALF) && addr_q[0])
                 || (is_word_size(size_q) && (addr_q[1:0] != 2'b00));
`else
  assign idx32   = {2'b00, addr_q[31:2]} % 32'(MEM_DEPTH);
  assign acc_err = 1'b0;
`endif

  assign mem_idx         = idx32[AW-1:0];
  assign unused_idx_bits = ^idx32[31:AW];

  // Byte offset of the addressed unit; misaligned low bits drop out here, so
  // without the error option a misaligned access simply aligns down.
  always_comb begin
    lane = 2'b00;
    case (size_q)
      SZ_BYTE: lane = addr_q[1:0];
      SZ_HALF: lane = {addr_q[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone choose
  // which bytes land.
  always_comb begin
    mem_be    = '1;
    mem_wdata = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        mem_be    = NB'(1) << lane;
        mem_wdata = {NB{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        mem_be    = NB'(3) << lane;
        mem_wdata = {(NB/2){wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_mask = '1;
    case (size_q)
      SZ_BYTE: load_mask = CELL_WIDTH'(8'hFF);
      SZ_HALF: load_mask = CELL_WIDTH'(16'hFFFF);
      default: ;
    endcase
  end

  assign load_data = (mem_rdata >> {lane, 3'b000}) & load_mask;

  // The access happens on the edge that leaves WAIT.
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we = access && we_q && !acc_err;

  mem_bus_array #(
    .CELL_WIDTH(CELL_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_array (
    .clk  (CLK),
    .we   (mem_we),
    .be   (mem_be),
    .idx  (mem_idx),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          cnt_d   = 4'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (we_q || acc_err) ? '0 : load_data;
          err_d   = acc_err;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_WORD;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  assign bus.req_ready = (state_q == IDLE) && ready_en_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed vector table, hand-written sequences
// (held req_valid, reset during WAIT, zero wait states) and randomized traffic
// checked against a behavioural memory model.
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  localparam int CW    = 32;
  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic CLK;
  logic RST;
  state_e dbg_state, dbg_state0;

  mem_bus_responder_if #(.CELL_WIDTH(CW)) bus ();
  mem_bus_responder_if #(.CELL_WIDTH(CW)) bus0 ();

  mem_bus_responder #(.CELL_WIDTH(CW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .dbg_state(dbg_state)
  );

  mem_bus_responder #(.CELL_WIDTH(CW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0), .dbg_state(dbg_state0)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain read-modify-write on an array of 32-bit words.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, output logic [31:0] rdata, output logic err);
    int unsigned idx;
    int unsigned off;
    int unsigned bytes;
    idx   = addr / 4;
    off   = addr % 4;
    bytes = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
    rdata = 32'h0;
    err   = 1'b0;
`ifdef MEM_BUS_RESPONDER_ERR_EN
    if (idx >= DEPTH || (off % bytes) != 0) begin
      err = 1'b1;
      return;
    end
`else
    idx = idx % DEPTH;
`endif
    off = off - (off % bytes);
    if (we) begin
      for (int b = 0; b < int'(bytes); b++)
        model_mem[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
    end else begin
      for (int b = 0; b < int'(bytes); b++)
        rdata[8*b +: 8] = model_mem[idx][8*(off+b) +: 8];
    end
  endtask

  // ---------------- driver ----------------
  task automatic scramble_req();
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_size  = 2'($urandom_range(0, 3));
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, output logic [31:0] rdata, output logic err,
                        output int lat);
    int guard;
    @(negedge CLK);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_size  = size;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 40) begin
      @(negedge CLK);
      guard++;
    end
    check("accept_timeout", 32'(guard < 40), 32'd1);
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (lat == 1) check("ready_low_busy", 32'(bus.req_ready), 32'd0);
      scramble_req();
    end while (!bus.rsp_valid && lat < 40);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(negedge CLK);
    check("pulse_one_cycle", 32'(bus.rsp_valid), 32'd0);
    check("rdata_held", bus.rsp_rdata, rdata);
    check("ready_after_resp", 32'(bus.req_ready), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  logic [31:0] rd, mrd;
  logic        er, mer;
  int          lat, guard;
  int          n_acc, n_pulse;
  int          acc_cyc [2];
  logic        b_set;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  int          r_sel;

  initial begin
    RST = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_size = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_size = '0;

    // Reset state, with a request pending that must not be taken.
    bus.req_valid = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    bus.req_valid = 1'b0;
    RST = 1'b1;
    #1;
    check("ready_at_release", 32'(bus.req_ready), 32'd0);
    @(negedge CLK);
    check("ready_first_edge", 32'(bus.req_ready), 32'd1);

    // Fill every word so the model starts fully defined.
    for (int i = 0; i < DEPTH; i++) begin
      r_wdata = $urandom;
      model_access(1'b1, 32'(4*i), r_wdata, SZ_WORD, mrd, mer);
      do_req(1'b1, 32'(4*i), r_wdata, SZ_WORD, rd, er, lat);
      check("init_store_rdata", rd, 32'd0);
    end

    tbl.push_back(mk(1, 32'h00, 32'hCAFEF00D, SZ_WORD, 32'h0, 0));
    tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, SZ_WORD, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        SZ_WORD, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h10, 32'h0,        SZ_WORD, 32'h0, 0));
    tbl.push_back(mk(1, 32'h11, 32'h123456AB, SZ_BYTE, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        SZ_WORD, 32'h0000AB00, 0));
    tbl.push_back(mk(0, 32'h11, 32'h0,        SZ_BYTE, 32'h000000AB, 0));
    tbl.push_back(mk(1, 32'h20, 32'h0,        SZ_WORD, 32'h0, 0));
    tbl.push_back(mk(1, 32'h22, 32'hFFFF1234, SZ_HALF, 32'h0, 0));
    tbl.push_back(mk(0, 32'h22, 32'h0,        SZ_HALF, 32'h00001234, 0));
    tbl.push_back(mk(0, 32'h20, 32'h0,        SZ_WORD, 32'h12340000, 0));
    tbl.push_back(mk(0, 32'h20, 32'h0,        2'd3,    32'h12340000, 0));
    tbl.push_back(mk(0, 32'h22, 32'h0,        SZ_BYTE, 32'h00000034, 0));
`ifdef MEM_BUS_RESPONDER_ERR_EN
    tbl.push_back(mk(0, 32'(4*DEPTH), 32'h0,  SZ_WORD, 32'h0, 1));
    tbl.push_back(mk(0, 32'h02, 32'h0,        SZ_WORD, 32'h0, 1));
    tbl.push_back(mk(0, 32'h23, 32'h0,        SZ_HALF, 32'h0, 1));
    tbl.push_back(mk(1, 32'h21, 32'h0000FFFF, SZ_HALF, 32'h0, 1));
`else
    tbl.push_back(mk(0, 32'(4*DEPTH), 32'h0,  SZ_WORD, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 32'h02, 32'h0,        SZ_WORD, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 32'h23, 32'h0,        SZ_HALF, 32'h00001234, 0));
    tbl.push_back(mk(1, 32'h21, 32'h0000BEEF, SZ_HALF, 32'h0, 0));
`endif
    tbl.push_back(mk(0, 32'h20, 32'h0, SZ_WORD,
`ifdef MEM_BUS_RESPONDER_ERR_EN
                     32'h12340000,
`else
                     32'h1234BEEF,
`endif
                     0));

    foreach (tbl[i]) begin
      model_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, mrd, mer);
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, rd, er, lat);
      check("tbl_latency", 32'(lat), 32'(WS + 2));
      check("tbl_rdata", rd, tbl[i].exp_rdata);
      check("tbl_err", 32'(er), 32'(tbl[i].exp_err));
    end

    // req_valid held high across two requests.
    @(negedge CLK);
    bus.req_we = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = 32'h11223344; bus.req_size = SZ_WORD;
    bus.req_valid = 1'b1;
    n_acc = 0; n_pulse = 0; b_set = 1'b0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int c = 0; c < 3*(WS+3) + 6; c++) begin
      if (c != 0) @(negedge CLK);
      if (bus.rsp_valid) n_pulse++;
      if (n_acc == 2) bus.req_valid = 1'b0;
      if (n_acc == 1 && !b_set) begin
        bus.req_we = 1'b0; bus.req_wdata = 32'h0; b_set = 1'b1;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (n_acc < 2) acc_cyc[n_acc] = c;
        n_acc++;
      end
    end
    model_access(1'b1, 32'h40, 32'h11223344, SZ_WORD, mrd, mer);
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_pulses", 32'(n_pulse), 32'd2);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(WS + 3));
    check("b2b_load_rdata", bus.rsp_rdata, 32'h11223344);

    // Reset during WAIT of a store: no response, storage untouched.
    model_access(1'b1, 32'h30, 32'hA5A5A5A5, SZ_WORD, mrd, mer);
    do_req(1'b1, 32'h30, 32'hA5A5A5A5, SZ_WORD, rd, er, lat);
    do_req(1'b0, 32'h30, 32'h0, SZ_WORD, rd, er, lat);
    check("pre_rst_load", rd, 32'hA5A5A5A5);
    @(negedge CLK);
    bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'h55; bus.req_size = SZ_WORD;
    bus.req_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    @(negedge CLK);
    check("wait_before_rst", 32'(dbg_state), 32'(WAIT));
    RST = 1'b0;
    #1;
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    n_pulse = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.rsp_valid) n_pulse++;
    end
    check("rst_no_pulse", 32'(n_pulse), 32'd0);
    model_access(1'b0, 32'h30, 32'h0, SZ_WORD, mrd, mer);
    do_req(1'b0, 32'h30, 32'h0, SZ_WORD, rd, er, lat);
    check("rst_word_kept", rd, mrd);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_wdata = $urandom;
      r_sel   = $urandom_range(0, 9);
      if (r_sel < 7)      r_addr = 32'($urandom_range(0, 4*DEPTH - 1));
      else if (r_sel < 9) r_addr = 32'($urandom_range(4*DEPTH, 16*DEPTH));
      else                r_addr = $urandom;
      model_access(r_we, r_addr, r_wdata, r_size, mrd, mer);
      exp_q.push_back(mrd);
      do_req(r_we, r_addr, r_wdata, r_size, rd, er, lat);
      check("rand_latency", 32'(lat), 32'(WS + 2));
      check("rand_rdata", rd, exp_q.pop_front());
      check("rand_err", 32'(er), 32'(mer));
    end

    // Zero wait states on the second instance.
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      bus0.req_we = (k == 0); bus0.req_addr = 32'h8; bus0.req_wdata = 32'h0BADC0DE;
      bus0.req_size = SZ_WORD; bus0.req_valid = 1'b1;
      guard = 0;
      while (!bus0.req_ready && guard < 20) begin
        @(negedge CLK);
        guard++;
      end
      @(posedge CLK);
      #1;
      bus0.req_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge CLK);
        lat++;
      end while (!bus0.rsp_valid && lat < 20);
      check("ws0_latency", 32'(lat), 32'd2);
      check("ws0_rdata", bus0.rsp_rdata, (k == 0) ? 32'h0 : 32'h0BADC0DE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
